// File: rtl/riscv_dmem_arbiter_if.sv
// Bundles the two requester ports and the bridge port of the data-memory arbiter.
interface riscv_dmem_arbiter_if #(
  parameter int LEN_W = 2
);
  logic             m0_req,    m1_req;
  logic             m0_we,     m1_we;
  logic [LEN_W-1:0] m0_len,    m1_len;
  logic [31:0]      m0_addr,   m1_addr;
  logic [31:0]      m0_wdata,  m1_wdata;
  logic             m0_gnt,    m1_gnt;
  logic             m0_rvalid, m1_rvalid;
  logic [31:0]      m0_rdata,  m1_rdata;
  logic             mem_we;
  logic [LEN_W-1:0] mem_len;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_len, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_len, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    output mem_we, mem_len, mem_addr, mem_wdata
  );

  // Requester/bridge side.
  modport master (
    output m0_req, m0_we, m0_len, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_len, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    input  mem_we, mem_len, mem_addr, mem_wdata
  );
endinterface

// File: rtl/riscv_dmem_arbiter.sv
// Two-requester arbiter for the data-memory/IO bridge: CPU (m0) has priority,
// m1 is forced through after STARVE_LIMIT consecutive denied cycles.
// Grants are combinational; load data returns registered one cycle later.
module riscv_dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 4
) (
  input  logic clk,
  input  logic rst,
  riscv_dmem_arbiter_if.slave bus
);
  localparam int              NUM_REQ = 2;
  localparam logic [CW-1:0]   LIMIT   = CW'(STARVE_LIMIT);

  logic [CW-1:0]              starve_cnt;
  logic                       force1, m0_gnt, m1_gnt;
  logic [NUM_REQ-1:0]         ld;
  logic [NUM_REQ-1:0]         rvalid_q;
  logic [NUM_REQ-1:0][31:0]   rdata_q;

  // Grant decision: m0 wins unless m1 has waited its full starvation budget.
  always_comb begin
    force1 = bus.m1_req && (starve_cnt == LIMIT);
    m1_gnt = bus.m1_req && (!bus.m0_req || force1);
    m0_gnt = bus.m0_req && !m1_gnt;
  end

  assign bus.m0_gnt = m0_gnt;
  assign bus.m1_gnt = m1_gnt;

  // Bridge mux: m1 only when granted, m0 otherwise; writes gated by the grant
  // so an idle cycle never stores.
  assign bus.mem_addr  = m1_gnt ? bus.m1_addr  : bus.m0_addr;
  assign bus.mem_wdata = m1_gnt ? bus.m1_wdata : bus.m0_wdata;
  assign bus.mem_len   = m1_gnt ? bus.m1_len   : bus.m0_len;
  assign bus.mem_we    = (m0_gnt && bus.m0_we) || (m1_gnt && bus.m1_we);

  // Starvation counter: consecutive cycles m1 requested but lost; any gap or win clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       starve_cnt <= '0;
    else if (!bus.m1_req || m1_gnt) starve_cnt <= '0;
    else                           starve_cnt <= starve_cnt + CW'(1);
  end

  // Per-requester granted-load strobe.
  assign ld[0] = m0_gnt && !bus.m0_we;
  assign ld[1] = m1_gnt && !bus.m1_we;

  // Read return: capture bridge data on a granted load, pulse rvalid for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        rvalid_q[k] <= ld[k];
        if (ld[k]) rdata_q[k] <= bus.mem_rdata;
      end
    end
  end

  assign bus.m0_rvalid = rvalid_q[0];
  assign bus.m1_rvalid = rvalid_q[1];
  assign bus.m0_rdata  = rdata_q[0];
  assign bus.m1_rdata  = rdata_q[1];
endmodule
